muldiv_sequencer: RTL and testbench

Multi-cycle signed MULT/DIV engine and sequencer behind the HI/LO registers. It gives control_unit the mult_done, div_done and div_zero handshake, and drives HI/LO write strobes. The block performs 32 iterative steps per operation, so control_unit holds its EXECUTE state until a done pulse arrives. One operation is in flight at a time; later requests are ignored while busy.

---
 rtl/muldiv_pkg.sv | 20 ++
 rtl/muldiv_signfix.sv | 34 +++
 rtl/muldiv_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle signed MULT/DIV sequencer:
// default data width, FSM state encoding and latched-operation codes.
package muldiv_pkg;

    localparam int DEF_DATA_W = 32;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MUL_RUN = 3'd1,
        S_DIV_RUN = 3'd2,
        S_FINISH  = 3'd3,
        S_DZERO   = 3'd4
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Sign handling around the unsigned iterative core: operand magnitudes on the
// way in, conditional two's-complement negation of the result on the way out.
module muldiv_signfix #(
    parameter int W = 32
) (
    input  logic [W-1:0]   op_a_i,
    input  logic [W-1:0]   op_b_i,
    input  logic [2*W-1:0] mag_i,
    input  logic           mult_mode_i,
    input  logic           neg_lo_i,
    input  logic           neg_hi_i,
    output logic [W-1:0]   abs_a_o,
    output logic [W-1:0]   abs_b_o,
    output logic [W-1:0]   hi_o,
    output logic [W-1:0]   lo_o
);

    logic [2*W-1:0] prod_fix;

    always_comb begin
        abs_a_o  = op_a_i[W-1] ? -op_a_i : op_a_i;
        abs_b_o  = op_b_i[W-1] ? -op_b_i : op_b_i;
        prod_fix = neg_lo_i ? -mag_i : mag_i;
        // A product negates as one 2W-bit value; quotient and remainder negate independently.
        if (mult_mode_i) begin
            hi_o = prod_fix[2*W-1:W];
            lo_o = prod_fix[W-1:0];
        end else begin
            hi_o = neg_hi_i ? -mag_i[2*W-1:W] : mag_i[2*W-1:W];
            lo_o = neg_lo_i ? -mag_i[W-1:0]   : mag_i[W-1:0];
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed multiply/divide engine behind HI/LO: one shift-add or
// restoring-subtract step per clock, with done/strobe handshake to control_unit.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_in,
    input  logic              start_mult,
    input  logic              start_div,
    input  logic              abort,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] hi_out,
    output logic [DATA_W-1:0] lo_out,
    output logic              hi_write,
    output logic              lo_write,
    output logic              mult_done,
    output logic              div_done,
    output logic              div_zero,
    output logic              busy,
    output logic [2:0]        dbg_state
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // Handshake: start_mult/start_div are single-cycle requests sampled only
    // when the engine is free (IDLE, or the FINISH cycle handing back to IDLE);
    // requests seen at any other time are dropped, never queued.

    state_t              state_q;
    op_t                 op_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] prod_q;
    logic [DATA_W-1:0]   mcand_q;
    logic                neg_lo_q;
    logic                neg_hi_q;
    logic [DATA_W-1:0]   hi_q;
    logic [DATA_W-1:0]   lo_q;
    logic                hi_wr_q;
    logic                lo_wr_q;
    logic                mult_done_q;
    logic                div_done_q;
    logic                div_zero_q;
    logic                busy_q;

    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_trial;
    logic [DATA_W:0]     div_diff;
    logic                div_ge;
    logic [DATA_W-1:0]   div_rem;
    logic [2*DATA_W-1:0] mul_step;
    logic [2*DATA_W-1:0] div_step;
    logic [2*DATA_W-1:0] step_d;
    logic [DATA_W-1:0]   abs_a;
    logic [DATA_W-1:0]   abs_b;
    logic [DATA_W-1:0]   fix_hi;
    logic [DATA_W-1:0]   fix_lo;

    // prod_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, prod_q[2*DATA_W-1:DATA_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        mul_step  = {mul_sum, prod_q[DATA_W-1:1]};
        div_trial = prod_q[2*DATA_W-1:DATA_W-1];
        div_ge    = (div_trial >= {1'b0, mcand_q});
        div_diff  = div_trial - {1'b0, mcand_q};
        div_rem   = div_ge ? div_diff[DATA_W-1:0] : div_trial[DATA_W-1:0];
        div_step  = {div_rem, prod_q[DATA_W-2:0], div_ge};
        step_d    = (op_q == OP_MULT) ? mul_step : div_step;
    end

    muldiv_signfix #(.W(DATA_W)) u_signfix (
        .op_a_i      (op_a),
        .op_b_i      (op_b),
        .mag_i       (step_d),
        .mult_mode_i (op_q == OP_MULT),
        .neg_lo_i    (neg_lo_q),
        .neg_hi_i    (neg_hi_q),
        .abs_a_o     (abs_a),
        .abs_b_o     (abs_b),
        .hi_o        (fix_hi),
        .lo_o        (fix_lo)
    );

    always_ff @(posedge clk or negedge reset_in) begin
        if (!reset_in) begin
            state_q     <= S_IDLE;
            op_q        <= OP_MULT;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            neg_lo_q    <= 1'b0;
            neg_hi_q    <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            hi_wr_q     <= 1'b0;
            lo_wr_q     <= 1'b0;
            mult_done_q <= 1'b0;
            div_done_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            hi_wr_q     <= 1'b0;
            lo_wr_q     <= 1'b0;
            mult_done_q <= 1'b0;
            div_done_q  <= 1'b0;
            div_zero_q  <= 1'b0;
            case (state_q)
                S_IDLE, S_FINISH: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    // abort beats any start; multiply beats a simultaneous divide.
                    if (!abort && start_mult) begin
                        state_q  <= S_MUL_RUN;
                        busy_q   <= 1'b1;
                        op_q     <= OP_MULT;
                        cnt_q    <= CNT_LAST;
                        mcand_q  <= abs_a;
                        prod_q   <= {{DATA_W{1'b0}}, abs_b};
                        neg_lo_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        neg_hi_q <= 1'b0;
                    end else if (!abort && start_div && (op_b != '0)) begin
                        state_q  <= S_DIV_RUN;
                        busy_q   <= 1'b1;
                        op_q     <= OP_DIV;
                        cnt_q    <= CNT_LAST;
                        mcand_q  <= abs_b;
                        prod_q   <= {{DATA_W{1'b0}}, abs_a};
                        neg_lo_q <= op_a[DATA_W-1] ^ op_b[DATA_W-1];
                        neg_hi_q <= op_a[DATA_W-1];
                    end else if (!abort && start_div) begin
                        state_q    <= S_DZERO;
                        busy_q     <= 1'b1;
                        div_done_q <= 1'b1;
                        div_zero_q <= 1'b1;
                    end
                end
                S_MUL_RUN, S_DIV_RUN: begin
                    if (abort) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        prod_q <= step_d;
                        cnt_q  <= cnt_q - CNT_ONE;
                        if (cnt_q == '0) begin
                            state_q     <= S_FINISH;
                            cnt_q       <= '0;
                            hi_q        <= fix_hi;
                            lo_q        <= fix_lo;
                            hi_wr_q     <= 1'b1;
                            lo_wr_q     <= 1'b1;
                            mult_done_q <= (op_q == OP_MULT);
                            div_done_q  <= (op_q == OP_DIV);
                        end
                    end
                end
                S_DZERO: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign hi_out    = hi_q;
    assign lo_out    = lo_q;
    assign hi_write  = hi_wr_q;
    assign lo_write  = lo_wr_q;
    assign mult_done = mult_done_q;
    assign div_done  = div_done_q;
    assign div_zero  = div_zero_q;
    assign busy      = busy_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed handshake scenarios plus
// randomized signed mult/div against a plain 64-bit arithmetic reference.
module tb_muldiv_sequencer;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset_in = 1'b0;
    logic          start_mult = 1'b0;
    logic          start_div = 1'b0;
    logic          abort = 1'b0;
    logic [W-1:0]  op_a = '0;
    logic [W-1:0]  op_b = '0;
    logic [W-1:0]  hi_out;
    logic [W-1:0]  lo_out;
    logic          hi_write;
    logic          lo_write;
    logic          mult_done;
    logic          div_done;
    logic          div_zero;
    logic          busy;
    logic [2:0]    dbg_state;

    int cmp_cnt = 0;
    int err_cnt = 0;
    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   last_hi = '0;
    logic [W-1:0]   last_lo = '0;

    muldiv_sequencer #(.DATA_W(W)) dut (
        .clk        (clk),
        .reset_in   (reset_in),
        .start_mult (start_mult),
        .start_div  (start_div),
        .abort      (abort),
        .op_a       (op_a),
        .op_b       (op_b),
        .hi_out     (hi_out),
        .lo_out     (lo_out),
        .hi_write   (hi_write),
        .lo_write   (lo_write),
        .mult_done  (mult_done),
        .div_done   (div_done),
        .div_zero   (div_zero),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    // {mult_done, div_done, div_zero, hi_write, lo_write, busy}
    function automatic logic [5:0] flags();
        return {mult_done, div_done, div_zero, hi_write, lo_write, busy};
    endfunction

    task automatic run_op(input bit is_mult, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit check_idle);
        longint pa, pb, r64;
        logic [2*W-1:0] exp_v;
        logic [5:0] exp_f;
        int lat, edges;
        bit got;
        pa = longint'($signed(a));
        pb = longint'($signed(b));
        if (is_mult) begin
            r64 = pa * pb;
            exp_q.push_back(r64);
            exp_f = 6'b100111;
            lat = W + 1;
        end else if (b == '0) begin
            exp_q.push_back({last_hi, last_lo});
            exp_f = 6'b011001;
            lat = 1;
        end else begin
            exp_q.push_back({W'(pa % pb), W'(pa / pb)});
            exp_f = 6'b010111;
            lat = W + 1;
        end
        @(negedge clk);
        op_a = a; op_b = b; start_mult = is_mult; start_div = !is_mult;
        edges = 0; got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            edges++;
            start_mult = 1'b0; start_div = 1'b0;
            if (mult_done || div_done) begin got = 1; break; end
        end
        exp_v = exp_q.pop_front();
        cmp_cnt++;
        if (!got || edges != lat) begin
            err_cnt++;
            $display("FAIL latency a=%h b=%h mult=%0d: got %0d edges (done seen=%0d), expected %0d",
                     a, b, is_mult, edges, got, lat);
        end
        cmp_cnt++;
        if ({hi_out, lo_out} !== exp_v) begin
            err_cnt++;
            $display("FAIL result a=%h b=%h mult=%0d: got hi=%h lo=%h, expected hi=%h lo=%h",
                     a, b, is_mult, hi_out, lo_out, exp_v[2*W-1:W], exp_v[W-1:0]);
        end
        cmp_cnt++;
        if (flags() !== exp_f) begin
            err_cnt++;
            $display("FAIL strobes a=%h b=%h mult=%0d: got %b, expected %b", a, b, is_mult, flags(), exp_f);
        end
        if (exp_f[2]) begin
            last_hi = exp_v[2*W-1:W];
            last_lo = exp_v[W-1:0];
        end
        if (check_idle) begin
            @(posedge clk); #1;
            cmp_cnt++;
            if (flags() !== 6'b0) begin
                err_cnt++;
                $display("FAIL idle_after a=%h b=%h: got flags %b, expected 000000", a, b, flags());
            end
        end
    endtask

    task automatic expect_quiet(input string name, input int cycles);
        int hits;
        hits = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (mult_done || div_done || hi_write || lo_write) hits++;
        end
        cmp_cnt++;
        if (hits != 0) begin
            err_cnt++;
            $display("FAIL %s: got %0d cycles with done/strobe, expected 0", name, hits);
        end
    endtask

    task automatic test_reset();
        #12;
        cmp_cnt++;
        if ({flags(), hi_out, lo_out} !== '0) begin
            err_cnt++;
            $display("FAIL reset: got flags %b hi=%h lo=%h, expected all zero", flags(), hi_out, lo_out);
        end
        @(negedge clk); reset_in = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_op(1'b1, 32'd7, 32'hFFFF_FFFD, 1'b1);
        run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b1);
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, 1'b1);
        run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        run_op(1'b0, 32'd7, 32'hFFFF_FFFE, 1'b1);
    endtask

    task automatic test_div_zero();
        run_op(1'b0, 32'h0000_0451, 32'h0000_0020, 1'b1);
        run_op(1'b0, 32'h1234_5678, 32'h0, 1'b1);
    endtask

    task automatic test_both_starts();
        int edges;
        bit got;
        @(negedge clk);
        op_a = 32'd5; op_b = 32'd6; start_mult = 1'b1; start_div = 1'b1;
        edges = 0; got = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk); #1;
            edges++;
            start_mult = 1'b0;
            start_div = (edges == 10);
            if (edges == 10) op_b = 32'd3;
            if (mult_done || div_done) begin got = 1; break; end
        end
        start_div = 1'b0;
        cmp_cnt++;
        if (!got || edges != W + 1 || flags() !== 6'b100111 || {hi_out, lo_out} !== 64'd30) begin
            err_cnt++;
            $display("FAIL both_starts: got edges=%0d flags=%b hi=%h lo=%h, expected 33 100111 0 1e",
                     edges, flags(), hi_out, lo_out);
        end
        last_hi = '0; last_lo = 32'd30;
        expect_quiet("busy_start_ignored", 40);
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        op_a = 32'hFFFF_0000 | $urandom_range(0, 65535); op_b = 32'd9; start_div = 1'b1;
        @(posedge clk); #1; start_div = 1'b0;
        repeat (19) @(posedge clk);
        #3 reset_in = 1'b0;
        #1;
        cmp_cnt++;
        if ({flags(), hi_out, lo_out} !== '0) begin
            err_cnt++;
            $display("FAIL reset_mid_run: got flags %b hi=%h lo=%h, expected all zero", flags(), hi_out, lo_out);
        end
        last_hi = '0; last_lo = '0;
        @(negedge clk); reset_in = 1'b1;
        expect_quiet("after_reset_quiet", 40);
    endtask

    task automatic test_abort();
        run_op(1'b1, 32'h0001_0003, 32'h0002_0005, 1'b1);
        @(negedge clk);
        op_a = 32'd1000; op_b = 32'd7; start_div = 1'b1;
        @(posedge clk); #1; start_div = 1'b0;
        repeat (18) @(posedge clk);
        @(negedge clk); abort = 1'b1;
        @(posedge clk); #1;
        cmp_cnt++;
        if (flags() !== 6'b0 || hi_out !== last_hi || lo_out !== last_lo) begin
            err_cnt++;
            $display("FAIL abort_run: got flags %b hi=%h lo=%h, expected 000000 hi=%h lo=%h",
                     flags(), hi_out, lo_out, last_hi, last_lo);
        end
        abort = 1'b0;
        expect_quiet("after_abort_quiet", 40);
        @(negedge clk); abort = 1'b1; start_mult = 1'b1; op_a = 32'd3; op_b = 32'd4;
        @(posedge clk); #1;
        abort = 1'b0; start_mult = 1'b0;
        cmp_cnt++;
        if (busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL abort_idle_start: got busy=%b, expected 0", busy);
        end
        expect_quiet("abort_idle_quiet", 40);
    endtask

    task automatic test_random_back_to_back();
        logic [W-1:0] corners[5];
        logic [W-1:0] a, b;
        bit is_mult, chk;
        corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFF_FFFF;
        corners[3] = 32'h8000_0000; corners[4] = 32'h7FFF_FFFF;
        for (int i = 0; i < 24; i++) begin
            is_mult = $urandom_range(0, 1);
            a = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
            if (!is_mult && $urandom_range(0, 5) == 0) b = '0;
            // A refused divide must return through IDLE before the next request.
            chk = (!is_mult && b == '0) || ($urandom_range(0, 1) == 1);
            run_op(is_mult, a, b, chk);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_div_zero();
        test_both_starts();
        test_reset_mid_run();
        test_abort();
        test_random_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
